// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered immediate-generation pipeline stage for the decode
//               path. Classifies the instruction format from the opcode,
//               extracts the sign/zero-extended immediate (XLEN 32 or 64,
//               including CSR zimm) and presents it together with the raw
//               instruction behind a valid/ready handshake with flush.
//
// Parameters  : XLEN - immediate width, 32 or 64 (anything else fails
//                      elaboration)
//               SKID - 1: two-entry stage (output + skid) with registered
//                      in_ready_o; 0: single output register, combinational
//                      in_ready_o
//
// Ports       : clk_i        in   1     clock, all state on rising edge
//               rst_i        in   1     synchronous active-high reset
//               flush_i      in   1     drop all held entries at next edge
//               in_valid_i   in   1     instruction valid
//               in_ready_o   out  1     stage can accept
//               instr_i      in   32    raw instruction word
//               out_valid_o  out  1     result valid
//               out_ready_i  in   1     consumer accepts
//               imm_o        out  XLEN  extended immediate
//               fmt_o        out  3     0 R,1 I,2 S,3 B,4 U,5 J,6 Z,7 ILL
//               instr_o      out  32    instruction aligned with imm_o
//
// Build option: IMM_SHAMT_CHK_EN - when defined, shift-immediate encodings
//               are validated and emit a zero-extended shamt; illegal shift
//               encodings are reported as ILL with a zero immediate.
//
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic [31:0]     instr_o
);

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_Z   = 3'd6;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OP32   = 7'b0111011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    typedef logic [XLEN-1:0] imm_t;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode (combinational, from the word currently offered)
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [2:0] w_fmt;
    imm_t       w_imm;
    logic [2:0] w_dec_fmt;
    imm_t       w_dec_imm;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];

    always_comb begin
        w_fmt = c_FMT_ILL;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC:                         w_fmt = c_FMT_U;
            c_OP_JAL:                                     w_fmt = c_FMT_J;
            c_OP_JALR, c_OP_LOAD, c_OP_IMM, c_OP_IMM32:   w_fmt = c_FMT_I;
            c_OP_STORE:                                   w_fmt = c_FMT_S;
            c_OP_BRANCH:                                  w_fmt = c_FMT_B;
            c_OP_OP, c_OP_OP32:                           w_fmt = c_FMT_R;
            // CSR immediate forms (funct3 1xx) carry a zimm in rs1
            c_OP_SYSTEM: w_fmt = w_funct3[2] ? c_FMT_Z : c_FMT_I;
            default:                                      w_fmt = c_FMT_ILL;
        endcase
    end

    // Signed casts widen from the immediate's own top bit (instr[31]),
    // which also gives the XLEN=64 sign extension of U-type for free.
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            c_FMT_I: w_imm = imm_t'($signed(instr_i[31:20]));
            c_FMT_S: w_imm = imm_t'($signed({instr_i[31:25], instr_i[11:7]}));
            c_FMT_B: w_imm = imm_t'($signed({instr_i[31], instr_i[7],
                                              instr_i[30:25], instr_i[11:8], 1'b0}));
            c_FMT_U: w_imm = imm_t'($signed({instr_i[31:12], 12'b0}));
            c_FMT_J: w_imm = imm_t'($signed({instr_i[31], instr_i[19:12],
                                              instr_i[20], instr_i[30:21], 1'b0}));
            c_FMT_Z: w_imm = imm_t'(instr_i[19:15]);
            default: w_imm = '0;
        endcase
    end

`ifdef IMM_SHAMT_CHK_EN
    logic       w_is_shift;
    logic       w_word_shift;
    logic       w_shamt_ok;
    logic [5:0] w_shamt;

    always_comb begin
        // funct3 001 (sll) and 101 (srl/sra) share the low two bits 01
        w_is_shift   = ((w_opcode == c_OP_IMM) || (w_opcode == c_OP_IMM32)) &&
                       (w_funct3[1:0] == 2'b01);
        w_word_shift = (w_opcode == c_OP_IMM32) || (XLEN == 32);
        if (w_word_shift) begin
            w_shamt    = {1'b0, instr_i[24:20]};
            w_shamt_ok = !instr_i[25] &&
                         ((instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000));
        end else begin
            w_shamt    = instr_i[25:20];
            w_shamt_ok = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
        end
        w_dec_fmt = w_fmt;
        w_dec_imm = w_imm;
        if (w_is_shift) begin
            if (w_shamt_ok) begin
                w_dec_imm = imm_t'(w_shamt);
            end else begin
                w_dec_fmt = c_FMT_ILL;
                w_dec_imm = '0;
            end
        end
    end
`else
    assign w_dec_fmt = w_fmt;
    assign w_dec_imm = w_imm;
`endif

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    logic        r_out_valid;
    imm_t        r_imm;
    logic [2:0]  r_fmt;
    logic [31:0] r_instr;
    logic        w_accept;
    logic        w_retire;

    assign out_valid_o = r_out_valid;
    assign imm_o       = r_imm;
    assign fmt_o       = r_fmt;
    assign instr_o     = r_instr;

    // A word offered during flush is never taken, even if ready is high.
    assign w_accept = in_valid_i && in_ready_o && !flush_i;
    assign w_retire = r_out_valid && out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic        r_in_ready;
            logic        r_skid_valid;
            imm_t        r_skid_imm;
            logic [2:0]  r_skid_fmt;
            logic [31:0] r_skid_instr;

            // Ready is registered: it tracks "skid entry empty", so a stall
            // seen by the consumer reaches the producer one cycle later and
            // the skid entry absorbs the word in flight.
            assign in_ready_o = r_in_ready;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_out_valid  <= 1'b0;
                    r_imm        <= '0;
                    r_fmt        <= '0;
                    r_instr      <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_imm   <= '0;
                    r_skid_fmt   <= '0;
                    r_skid_instr <= '0;
                    r_in_ready   <= 1'b1;
                end else if (flush_i) begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (r_skid_valid) begin
                    // Ready is low here, so only the skid-to-output move
                    // can happen; it keeps order and leaves no bubble.
                    if (w_retire) begin
                        r_imm        <= r_skid_imm;
                        r_fmt        <= r_skid_fmt;
                        r_instr      <= r_skid_instr;
                        r_skid_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                end else if (w_accept) begin
                    if (!r_out_valid || out_ready_i) begin
                        r_out_valid <= 1'b1;
                        r_imm       <= w_dec_imm;
                        r_fmt       <= w_dec_fmt;
                        r_instr     <= instr_i;
                    end else begin
                        r_skid_valid <= 1'b1;
                        r_skid_imm   <= w_dec_imm;
                        r_skid_fmt   <= w_dec_fmt;
                        r_skid_instr <= instr_i;
                        r_in_ready   <= 1'b0;
                    end
                end else if (w_retire) begin
                    r_out_valid <= 1'b0;
                end
            end
        end else begin : g_direct
            assign in_ready_o = !r_out_valid || out_ready_i;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_out_valid <= 1'b0;
                    r_imm       <= '0;
                    r_fmt       <= '0;
                    r_instr     <= '0;
                end else if (flush_i) begin
                    r_out_valid <= 1'b0;
                end else if (w_accept) begin
                    // Covers simultaneous retire: the new word replaces it.
                    r_out_valid <= 1'b1;
                    r_imm       <= w_dec_imm;
                    r_fmt       <= w_dec_fmt;
                    r_instr     <= instr_i;
                end else if (w_retire) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench for imm_gen_pipe. Two instances are driven:
//               XLEN=32 with the skid buffer and XLEN=64 without it. Expected
//               results are queued when a word is known to be accepted; a
//               negedge monitor compares the queue head whenever an output is
//               valid and pops it on retire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] instr;
    } exp_t;

    logic r_clk;
    logic r_rst;

    logic        r_f32, r_iv32, r_or32;
    logic [31:0] r_in32;
    logic        w_ir32, w_ov32;
    logic [31:0] w_imm32, w_io32;
    logic [2:0]  w_fm32;

    logic        r_f64, r_iv64, r_or64;
    logic [31:0] r_in64;
    logic        w_ir64, w_ov64;
    logic [63:0] w_imm64;
    logic [31:0] w_io64;
    logic [2:0]  w_fm64;

    exp_t q32[$];
    exp_t q64[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    imm_gen_pipe #(.XLEN(32), .SKID(1)) u_dut32 (
        .clk_i(r_clk), .rst_i(r_rst), .flush_i(r_f32),
        .in_valid_i(r_iv32), .in_ready_o(w_ir32), .instr_i(r_in32),
        .out_valid_o(w_ov32), .out_ready_i(r_or32),
        .imm_o(w_imm32), .fmt_o(w_fm32), .instr_o(w_io32)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(0)) u_dut64 (
        .clk_i(r_clk), .rst_i(r_rst), .flush_i(r_f64),
        .in_valid_i(r_iv64), .in_ready_o(w_ir64), .instr_i(r_in64),
        .out_valid_o(w_ov64), .out_ready_i(r_or64),
        .imm_o(w_imm64), .fmt_o(w_fm64), .instr_o(w_io64)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge r_clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] w, input logic [63:0] imm, input logic [2:0] fmt);
        exp_t e;
        e.imm   = imm;
        e.fmt   = fmt;
        e.instr = w;
        return e;
    endfunction

    // Monitor: head of queue must be on the outputs while valid (this also
    // proves stability during stalls); pop on retire.
    always @(negedge r_clk) begin
        if (w_ov32) begin
            if (q32.size() == 0) begin
                check("d32 unexpected output", 64'(w_ov32), 64'd0);
            end else begin
                check("d32 imm", {32'd0, w_imm32}, q32[0].imm);
                check("d32 fmt", 64'(w_fm32), 64'(q32[0].fmt));
                check("d32 instr", 64'(w_io32), 64'(q32[0].instr));
                if (r_or32) void'(q32.pop_front());
            end
        end
        if (w_ov64) begin
            if (q64.size() == 0) begin
                check("d64 unexpected output", 64'(w_ov64), 64'd0);
            end else begin
                check("d64 imm", w_imm64, q64[0].imm);
                check("d64 fmt", 64'(w_fm64), 64'(q64[0].fmt));
                check("d64 instr", 64'(w_io64), 64'(q64[0].instr));
                if (r_or64) void'(q64.pop_front());
            end
        end
    end

    // Hand-decoded words used below
    localparam logic [31:0] c_W_ADDI_M1 = 32'hFFF00093; // imm -1, I
    localparam logic [31:0] c_W_SW      = 32'hFE112E23; // imm -4, S
    localparam logic [31:0] c_W_BEQ     = 32'hFE000CE3; // imm -8, B
    localparam logic [31:0] c_W_LUI     = 32'h123450B7; // 0x12345000, U
    localparam logic [31:0] c_W_LUI_NEG = 32'h800000B7; // 0x80000000, U
    localparam logic [31:0] c_W_CSRRWI  = 32'h300FD073; // zimm 31, Z
    localparam logic [31:0] c_W_ILL     = 32'h0000007F; // ILL
    localparam logic [31:0] c_W_ADDI_5  = 32'h00500113; // imm 5, I
    localparam logic [31:0] c_W_LUI2    = 32'h12345037; // 0x12345000, U
    localparam logic [31:0] c_W_SLLI32  = 32'h02009093; // slli shamt 32

    initial begin
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;

        r_rst = 1'b1;
        r_f32 = 1'b0; r_iv32 = 1'b0; r_or32 = 1'b0; r_in32 = '0;
        r_f64 = 1'b0; r_iv64 = 1'b0; r_or64 = 1'b0; r_in64 = '0;
        tick;
        tick;

        // Reset state
        check("d32 reset out_valid", 64'(w_ov32), 64'd0);
        check("d32 reset in_ready", 64'(w_ir32), 64'd1);
        check("d32 reset imm", 64'(w_imm32), 64'd0);
        check("d32 reset fmt", 64'(w_fm32), 64'd0);
        check("d32 reset instr", 64'(w_io32), 64'd0);
        check("d64 reset out_valid", 64'(w_ov64), 64'd0);
        check("d64 reset in_ready", 64'(w_ir64), 64'd1);
        check("d64 reset imm", w_imm64, 64'd0);
        r_rst = 1'b0;
        tick;

        // XLEN=32: addi -1, one-cycle latency
        r_or32 = 1'b1; r_iv32 = 1'b1; r_in32 = c_W_ADDI_M1;
        q32.push_back(mk(c_W_ADDI_M1, 64'hFFFF_FFFF, 3'd1));
        tick;
        check("d32 addi latency valid", 64'(w_ov32), 64'd1);
        check("d32 addi imm", 64'(w_imm32), 64'hFFFF_FFFF);
        check("d32 addi fmt", 64'(w_fm32), 64'd1);

        // Back-to-back S, B, U
        r_in32 = c_W_SW;  q32.push_back(mk(c_W_SW,  64'hFFFF_FFFC, 3'd2)); tick;
        check("d32 S imm", 64'(w_imm32), 64'hFFFF_FFFC);
        r_in32 = c_W_BEQ; q32.push_back(mk(c_W_BEQ, 64'hFFFF_FFF8, 3'd3)); tick;
        check("d32 B imm", 64'(w_imm32), 64'hFFFF_FFF8);
        r_in32 = c_W_LUI; q32.push_back(mk(c_W_LUI, 64'h1234_5000, 3'd4)); tick;
        check("d32 U imm", 64'(w_imm32), 64'h1234_5000);
        check("d32 U fmt", 64'(w_fm32), 64'd4);

        // Shift immediate with shamt 32 on XLEN=32
`ifdef IMM_SHAMT_CHK_EN
        e_imm = 64'd0;  e_fmt = 3'd7;
`else
        e_imm = 64'h20; e_fmt = 3'd1;
`endif
        r_in32 = c_W_SLLI32; q32.push_back(mk(c_W_SLLI32, e_imm, e_fmt)); tick;
        check("d32 slli32 fmt", 64'(w_fm32), 64'(e_fmt));
        check("d32 slli32 imm", 64'(w_imm32), e_imm);
        r_iv32 = 1'b0;
        tick;
        check("d32 drained", 64'(w_ov32), 64'd0);

        // XLEN=64, no skid: back-to-back with same-edge replace
        r_or64 = 1'b1; r_iv64 = 1'b1;
        r_in64 = c_W_LUI_NEG; q64.push_back(mk(c_W_LUI_NEG, 64'hFFFF_FFFF_8000_0000, 3'd4)); tick;
        check("d64 U neg imm", w_imm64, 64'hFFFF_FFFF_8000_0000);
        r_in64 = c_W_CSRRWI;  q64.push_back(mk(c_W_CSRRWI, 64'h1F, 3'd6)); tick;
        check("d64 zimm imm", w_imm64, 64'h1F);
        check("d64 zimm fmt", 64'(w_fm64), 64'd6);
        r_in64 = c_W_ILL;     q64.push_back(mk(c_W_ILL, 64'd0, 3'd7)); tick;
        check("d64 ILL fmt", 64'(w_fm64), 64'd7);
        check("d64 ILL imm", w_imm64, 64'd0);
        r_in64 = c_W_ADDI_M1; q64.push_back(mk(c_W_ADDI_M1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1)); tick;
        check("d64 addi imm", w_imm64, 64'hFFFF_FFFF_FFFF_FFFF);

        // Stall: output held, ready low, offered word not taken
        r_or64 = 1'b0; r_in64 = c_W_LUI;
        tick;
        check("d64 stall in_ready", 64'(w_ir64), 64'd0);
        check("d64 stall held imm", w_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        r_or64 = 1'b1; q64.push_back(mk(c_W_LUI, 64'h1234_5000, 3'd4));
        tick;
        check("d64 replace valid", 64'(w_ov64), 64'd1);
        check("d64 replace imm", w_imm64, 64'h1234_5000);
        r_iv64 = 1'b0;
        tick;
        check("d64 drained", 64'(w_ov64), 64'd0);
        r_or64 = 1'b0;

        // XLEN=32 skid: three stalled edges, two words accepted, third refused
        r_or32 = 1'b0; r_iv32 = 1'b1;
        r_in32 = c_W_ADDI_5; q32.push_back(mk(c_W_ADDI_5, 64'd5, 3'd1)); tick;
        check("d32 skid first in_ready", 64'(w_ir32), 64'd1);
        r_in32 = c_W_LUI2; q32.push_back(mk(c_W_LUI2, 64'h1234_5000, 3'd4)); tick;
        check("d32 skid full in_ready", 64'(w_ir32), 64'd0);
        check("d32 skid held imm", 64'(w_imm32), 64'd5);
        r_in32 = c_W_ADDI_M1; tick;
        check("d32 skid still full", 64'(w_ir32), 64'd0);
        check("d32 skid still held", 64'(w_imm32), 64'd5);
        r_iv32 = 1'b0; r_or32 = 1'b1; tick;
        check("d32 skid no bubble", 64'(w_ov32), 64'd1);
        check("d32 skid second imm", 64'(w_imm32), 64'h1234_5000);
        check("d32 skid ready back", 64'(w_ir32), 64'd1);
        tick;
        check("d32 skid drained", 64'(w_ov32), 64'd0);

        // Flush with both entries full and a new word offered
        r_or32 = 1'b0; r_iv32 = 1'b1;
        r_in32 = c_W_ADDI_5; q32.push_back(mk(c_W_ADDI_5, 64'd5, 3'd1)); tick;
        r_in32 = c_W_LUI2;   q32.push_back(mk(c_W_LUI2, 64'h1234_5000, 3'd4)); tick;
        r_f32 = 1'b1; r_in32 = c_W_SW; tick;
        q32.delete();
        r_f32 = 1'b0; r_iv32 = 1'b0;
        check("d32 flush out_valid", 64'(w_ov32), 64'd0);
        check("d32 flush in_ready", 64'(w_ir32), 64'd1);
        tick;
        check("d32 flush nothing emitted", 64'(w_ov32), 64'd0);

        // Flush with in_ready high: offered word must be dropped
        r_iv32 = 1'b1; r_in32 = c_W_ADDI_5; q32.push_back(mk(c_W_ADDI_5, 64'd5, 3'd1)); tick;
        check("d32 one entry in_ready", 64'(w_ir32), 64'd1);
        r_f32 = 1'b1; r_in32 = c_W_BEQ; tick;
        q32.delete();
        r_f32 = 1'b0; r_iv32 = 1'b0;
        check("d32 flush drops offered", 64'(w_ov32), 64'd0);
        r_or32 = 1'b1; tick; tick;
        r_or32 = 1'b0;

        // Reset mid-stall with both entries full
        r_iv32 = 1'b1;
        r_in32 = c_W_ADDI_5; q32.push_back(mk(c_W_ADDI_5, 64'd5, 3'd1)); tick;
        r_in32 = c_W_LUI2;   q32.push_back(mk(c_W_LUI2, 64'h1234_5000, 3'd4)); tick;
        r_iv32 = 1'b0; r_rst = 1'b1; r_f32 = 1'b1; tick;
        q32.delete(); q64.delete();
        check("d32 stall reset out_valid", 64'(w_ov32), 64'd0);
        check("d32 stall reset in_ready", 64'(w_ir32), 64'd1);
        check("d32 stall reset imm", 64'(w_imm32), 64'd0);
        check("d32 stall reset fmt", 64'(w_fm32), 64'd0);
        check("d32 stall reset instr", 64'(w_io32), 64'd0);
        r_rst = 1'b0; r_f32 = 1'b0;
        tick;
        check("d32 after reset empty", 64'(w_ov32), 64'd0);

        // Skid must be empty after reset: one word in, one word out
        r_or32 = 1'b1; r_iv32 = 1'b1;
        r_in32 = c_W_BEQ; q32.push_back(mk(c_W_BEQ, 64'hFFFF_FFF8, 3'd3)); tick;
        check("d32 post-reset imm", 64'(w_imm32), 64'hFFFF_FFF8);
        r_iv32 = 1'b0;
        tick;
        check("d32 post-reset single", 64'(w_ov32), 64'd0);

        for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) tick;
        check("scoreboard drained", 64'(q32.size() + q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered immediate-generation stage for the decode path; successor to the combinational immediate generator.
- Decodes the instruction format from the opcode itself; no external type input.
- Generalised to XLEN 32/64 and adds CSR zimm extraction.
- Uses a valid/ready handshake with flush and an optional skid buffer, so it sits as a pipeline stage between fetch and register read.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64, anything else is an elaboration error.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single output register with combinational ready.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous, active-high reset
- flush_i  input  1  drop all held entries at next edge
- in_valid_i  input  1  instruction valid
- in_ready_o  output  1  stage can accept
- instr_i  input  32  raw instruction word
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts
- imm_o  output  XLEN  sign/zero-extended immediate
- fmt_o  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 ILL
- instr_o  output  32  instruction passthrough aligned with imm_o

Behaviour:
- Opcode map for instr[6:0]:
  - U: 0110111, 0010111
  - J: 1101111
  - I: 1100111, 0000011, 0010011, 0011011
  - S: 0100011
  - B: 1100011
  - R: 0110011, 0111011
  - 1110011: funct3[2]=1 -> Z; otherwise I
  - anything else -> ILL
- Immediate rules (standard RV32I bit scatter, then sign-extended from instr[31] to XLEN):
  - R and ILL: 0
  - U: {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64
  - Z: zero-extended instr[19:15]
- Handshake: transfer on in_valid_i&&in_ready_o (accept) and out_valid_o&&out_ready_i (retire).
- Latency: exactly 1 cycle from accept to out_valid_o with an empty stage.
- SKID=0:
  - in_ready_o = !out_valid_o || out_ready_i.
  - Simultaneous accept and retire replaces the output register in the same edge.
- SKID=1:
  - in_ready_o is a flop, high when the skid entry is empty.
  - Accept while the output is held and not retiring parks the word in the skid entry.
  - Next retire moves skid -> output, with no bubble and no reordering.
  - Full (both entries occupied) -> in_ready_o=0 the following cycle.
- Output stability: while out_valid_o && !out_ready_i, imm_o/fmt_o/instr_o are held constant.
- Flush:
  - Clears out_valid_o and the skid entry at the next edge.
  - Any word offered in the flush cycle is discarded even if in_ready_o=1.
  - in_ready_o=1 the cycle after.
- Reset, at any time including mid-stall:
  - out_valid_o=0, in_ready_o=1 (SKID=1 flop resets to 1), imm_o=0, fmt_o=0, instr_o=0, skid entry invalid.
  - Reset dominates flush.
- Data registers update only on accept/move; no X propagation.

Optional Feature:
- IMM_SHAMT_CHK_EN.
- When defined:
  - Shift-immediate instructions are checked: OP-IMM funct3 001/101, and OP-IMM-32.
  - Shamt width is 5 for XLEN=32 and OP-IMM-32, 6 for XLEN=64.
  - A nonzero bit above that width, or an illegal funct7 (anything other than 0000000/0100000 in the upper bits), forces fmt_o=7 and imm_o=0.
  - Legal shifts output zero-extended shamt instead of sign-extended imm.
- When undefined: shifts are treated as plain I-type, with imm sign-extended from instr[31:20].

Test Plan:
- XLEN=32, accept 0xFFF00093 (addi x1,x0,-1) -> 1 cycle later out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1.
- Sequence 0xFE112E23, 0xFE000CE3, 0x123450B7, out_ready_i=1 -> imm 0xFFFFFFFC/S, 0xFFFFFFF8/B, 0x12345000/U on consecutive cycles.
- XLEN=64:
  - 0x800000B7 -> 0xFFFFFFFF80000000, fmt 4.
  - 0x300FD073 (csrrwi mstatus,31) -> 0x1F, fmt 6.
  - 0x0000007F -> imm 0, fmt 7.
- SKID=1, out_ready_i=0 for 3 cycles while offering two words -> second parked, in_ready_o=0; release -> both retire in order, no bubble, output held stable during stall.
- flush_i asserted with both entries full and a new in_valid_i -> next cycle out_valid_o=0, nothing emitted, in_ready_o=1.
- rst_i asserted during stall -> all outputs 0, in_ready_o=1; with IMM_SHAMT_CHK_EN, XLEN=32: 0x02009093 (slli shamt 32) -> fmt 7, imm 0.
